bcd_scan_decoder: RTL

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

---
 rtl/bcd_scan_decoder.sv | 110 +++++++++++
 1 files changed

// File: rtl/bcd_scan_decoder.sv
// Serialises a packed BCD word into per-digit decimal one-hot beats over a
// valid/ready stream, flagging non-decimal codes and counting them.
module bcd_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter bit MSD_FIRST  = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        y,
    output logic [IW-1:0]     digit_idx,
    output logic              last,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        err_count
);

    localparam logic [IW-1:0] FIRST_IDX = MSD_FIRST ? IW'(DIGITS - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX  = MSD_FIRST ? '0 : IW'(DIGITS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] word;
    logic [9:0]          y_hot;
    logic                load, advance, done;
    logic [IW-1:0]       idx_nxt;
    logic [4*DIGITS-1:0] word_src;
    logic [3:0]          dig;
    logic [9:0]          y_hot_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (in_valid) begin
                load      = 1'b1;
                state_nxt = SCAN;
            end
            SCAN: if (out_ready) begin
                if (last) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next beat is decoded from bcd_in directly on capture so the first digit
    // is ready one cycle after the input handshake.
    always_comb begin
        idx_nxt   = load ? FIRST_IDX : (MSD_FIRST ? digit_idx - 1'b1 : digit_idx + 1'b1);
        word_src  = load ? bcd_in : word;
        dig       = word_src[{idx_nxt, 2'b00} +: 4];
        y_hot_nxt = (dig <= 4'd9) ? (10'd1 << dig) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            y_hot     <= '0;
            digit_idx <= '0;
            last      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (load) word <= bcd_in;
            if (load || advance) begin
                y_hot     <= y_hot_nxt;
                digit_idx <= idx_nxt;
                last      <= (idx_nxt == LAST_IDX);
                err       <= (dig > 4'd9);
            end else if (done) begin
                y_hot     <= '0;
                digit_idx <= '0;
                last      <= 1'b0;
                err       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (err_clr)
            err_count <= '0;
        else if (out_valid && out_ready && err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign y         = ACTIVE_LOW ? ~y_hot : y_hot;

endmodule
